c2_dispatch_hub: RTL and testbench
==================================

// Module: c2_dispatch_hub
// PURPOSE
//  Parametrised C2 command dispatcher between the UART PHY and N functional units (loader, debugger, ...).
//  Decodes a command byte to {unit, mode}, ACKs it and optionally pulses a core soft reset.
//  Then grants that unit exclusive RX/TX until it reports done. Adds NAK replies and a per-session inactivity watchdog.
// PARAMETERS
//  N_UNITS     3          number of client units (1..8)
//  N_MODES     2          modes per unit, power of two (1..16)
//  CMD_BASE    8'h40      first valid command byte
//  RESET_MASK  3'b011     bit u=1: commands for unit u pulse soft_reset_o
//  RESET_CYC   4          soft_reset_o pulse length, cycles (>=1)
//  TIMEOUT_CYC 1_000_000  idle cycles in grant before forced release; 0 disables
//  ACK_BYTE    8'h06      sent after a valid command
//  NAK_CMD     8'h15      sent after an invalid command
//  NAK_TMO     8'h18      sent after a watchdog release
// PORTS
//  clk_i            in   1            system clock
//  rst_ni           in   1            asynchronous active-low reset
//  rx_data_i        in   8            UART received byte
//  rx_valid_i       in   1            1-cycle strobe, rx_data_i valid
//  tx_data_o        out  8            byte to UART TX
//  tx_start_o       out  1            1-cycle TX start strobe
//  tx_done_i        in   1            1-cycle UART TX completion strobe
//  grant_o          out  N_UNITS      one-hot session grant
//  mode_o           out  $clog2(N_MODES) (min 1)  decoded mode, stable while granted
//  unit_rx_valid_o  out  N_UNITS      rx_valid_i gated to granted unit
//  unit_tx_data_i   in   8*N_UNITS    per-unit TX byte, unit u at [8u+:8]
//  unit_tx_start_i  in   N_UNITS      per-unit TX start
//  unit_done_i      in   N_UNITS      per-unit session-complete strobe
//  unit_abort_o     out  N_UNITS      1-cycle abort to unit on watchdog release
//  soft_reset_o     out  1            core flush / PC reset pulse
//  busy_o           out  1            1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; watchdog cleared; latched unit/mode 0.
//  Decode: idx = rx_data_i - CMD_BASE, 8-bit unsigned compare.
//   Valid iff rx_data_i >= CMD_BASE and idx < N_UNITS*N_MODES.
//   unit = idx >> log2(N_MODES); mode = idx & (N_MODES-1).
//  FSM IDLE -> ACK -> GRANT -> IDLE, plus IDLE -> NAK -> IDLE and GRANT -> NAK -> IDLE:
//  - IDLE: on rx_valid_i, latch unit/mode.
//    Valid command -> ACK: tx_data_o=ACK_BYTE, tx_start_o=1 on the next cycle (registered, latency 1).
//    If RESET_MASK[unit], soft_reset_o=1 for RESET_CYC cycles starting that same cycle.
//    Invalid command -> NAK with tx_data_o=NAK_CMD, same timing.
//  - ACK: wait tx_done_i; GRANT entered the cycle after, and soft reset must have finished first.
//    If RESET_CYC outlasts the byte, stay until the pulse ends.
//  - GRANT: grant_o[unit]=1, mode_o=mode, unit_rx_valid_o[unit]=rx_valid_i (combinational).
//    tx_data_o/tx_start_o = unit_tx_data_i/unit_tx_start_i of the granted unit (combinational pass-through).
//    Inputs from non-granted units are ignored.
//  - Watchdog (GRANT only): counter cleared on entry and on any rx_valid_i, unit TX start or tx_done_i; otherwise +1.
//    When it reaches TIMEOUT_CYC-1: drop grant, pulse unit_abort_o[unit] for 1 cycle, go to NAK.
//    The NAK sends NAK_TMO, first waiting for any in-flight unit byte's tx_done_i.
//  - unit_done_i[unit] in GRANT -> grant_o=0 the next cycle, return to IDLE.
//    If done and timeout coincide, done wins: no abort, no NAK.
//  - NAK: wait tx_done_i -> IDLE.
//  - RX bytes arriving in ACK/NAK are dropped, never forwarded or decoded.
//  - Counters saturate, never wrap.
//  - Reset mid-session: immediate return to reset values, no abort pulse.
// STRUCTURE
//  c2_pkg (shared): c2_hub_state_e {IDLE,ACK,GRANT,NAK}, ACK/NAK byte constants.
//  Sub-module c2_watchdog #(TIMEOUT_CYC): clear_i, en_i -> expired_o; width $clog2(TIMEOUT_CYC+1); tie expired_o=0 when TIMEOUT_CYC=0.
//  Hub holds FSM, decoder, soft-reset counter and TX mux.
// TESTING (defaults, TIMEOUT_CYC=64 in bench)
//  1. rx 0x43 -> tx 0x06 next cycle, soft_reset_o 4 cycles; after tx_done, grant_o=3'b010, mode_o=1.
//  2. rx 0x44 -> ACK, no soft reset; grant_o=3'b100; unit2 tx 0xAB passes; unit_done_i[2] -> grant 0, busy_o 0.
//  3. rx 0x46 and 0x3F -> each tx 0x15, grant_o stays 0.
//  4. grant unit0, no activity 64 cycles -> unit_abort_o=3'b001 for 1 cycle, tx 0x18, IDLE.
//  5. unit_done_i[0] in the cycle the watchdog expires -> no abort, no NAK; unit_done_i[1] while unit0 granted -> ignored.
//  6. rst_ni low during GRANT -> all outputs 0 asynchronously; next rx 0x40 is decoded normally.

Source files
------------

// File: rtl/c2_pkg.sv
// Shared types and protocol constants for the C2 command dispatcher.
package c2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        GRANT = 2'd2,
        NAK   = 2'd3
    } c2_hub_state_e;

    localparam logic [7:0] C2_CMD_BASE = 8'h40;
    localparam logic [7:0] C2_ACK_BYTE = 8'h06;
    localparam logic [7:0] C2_NAK_CMD  = 8'h15;
    localparam logic [7:0] C2_NAK_TMO  = 8'h18;

endpackage

// File: rtl/c2_watchdog.sv
// Session inactivity watchdog: counts enabled idle cycles, flags expiry at TIMEOUT_CYC-1.
// A TIMEOUT_CYC of zero removes the counter entirely.
module c2_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    if (TIMEOUT_CYC == 0) begin : g_off
        logic unused_inputs;
        assign unused_inputs = ^{clk_i, rst_ni, clear_i, en_i};
        assign expired_o     = 1'b0;
    end else begin : g_on
        localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
        localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

        logic [CW-1:0] cnt_q, cnt_d;

        // Saturates at LAST so a stalled FSM can never see the count wrap.
        always_comb begin
            cnt_d = cnt_q;
            if (clear_i) begin
                cnt_d = '0;
            end else if (en_i && (cnt_q != LAST)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expired_o = en_i && (cnt_q == LAST);
    end

endmodule

// File: rtl/c2_dispatch_hub.sv
// C2 command dispatcher: decodes a command byte, ACK/NAKs it, optionally pulses a core
// soft reset, then grants one unit exclusive RX/TX until it finishes or goes idle too long.
module c2_dispatch_hub
    import c2_pkg::*;
#(
    parameter int unsigned          N_UNITS     = 3,
    parameter int unsigned          N_MODES     = 2,
    parameter logic [7:0]           CMD_BASE    = C2_CMD_BASE,
    parameter logic [N_UNITS-1:0]   RESET_MASK  = 3'b011,
    parameter int unsigned          RESET_CYC   = 4,
    parameter int unsigned          TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0]           ACK_BYTE    = C2_ACK_BYTE,
    parameter logic [7:0]           NAK_CMD     = C2_NAK_CMD,
    parameter logic [7:0]           NAK_TMO     = C2_NAK_TMO
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_valid_i,
    output logic [7:0]               tx_data_o,
    output logic                     tx_start_o,
    input  logic                     tx_done_i,
    output logic [N_UNITS-1:0]       grant_o,
    output logic [((N_MODES > 1) ? $clog2(N_MODES) : 1)-1:0] mode_o,
    output logic [N_UNITS-1:0]       unit_rx_valid_o,
    input  logic [8*N_UNITS-1:0]     unit_tx_data_i,
    input  logic [N_UNITS-1:0]       unit_tx_start_i,
    input  logic [N_UNITS-1:0]       unit_done_i,
    output logic [N_UNITS-1:0]       unit_abort_o,
    output logic                     soft_reset_o,
    output logic                     busy_o
);

    localparam int unsigned UW        = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int unsigned MODE_BITS = $clog2(N_MODES);
    localparam int unsigned MW        = (MODE_BITS > 0) ? MODE_BITS : 1;
    localparam int unsigned N_CMDS    = N_UNITS * N_MODES;
    localparam int unsigned RW        = $clog2(RESET_CYC + 1);

    c2_hub_state_e      state_q, state_d;
    logic [UW-1:0]      unit_q, unit_d;
    logic [MW-1:0]      mode_q, mode_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic [N_UNITS-1:0] abort_q, abort_d;
    logic [RW-1:0]      srst_cnt_q, srst_cnt_d;
    logic               soft_reset_q, soft_reset_d;
    logic               inflight_q, inflight_d;
    logic               byte_done_q, byte_done_d;
    logic               nak_sent_q, nak_sent_d;

    logic [7:0]         cmd_idx;
    logic               cmd_valid;
    logic [UW-1:0]      cmd_unit;
    logic [MW-1:0]      cmd_mode;
    logic               cmd_rst;

    logic [N_UNITS-1:0] grant_oh;
    logic [7:0]         sel_tx_data;
    logic               sel_tx_start;
    logic               sel_done;
    logic               in_grant;
    logic               activity;
    logic               wd_clear;
    logic               wd_expired;
    logic               timeout;

    // Command decode; the subtraction wraps, so the >= check rejects bytes below the base.
    always_comb begin
        cmd_idx   = rx_data_i - CMD_BASE;
        cmd_valid = (rx_data_i >= CMD_BASE) && ({1'b0, cmd_idx} < 9'(N_CMDS));
        cmd_unit  = UW'(cmd_idx >> MODE_BITS);
        cmd_mode  = MW'(cmd_idx & 8'(N_MODES - 1));
        cmd_rst   = 1'b0;
        for (int unsigned u = 0; u < N_UNITS; u++) begin
            if (cmd_unit == UW'(u)) begin
                cmd_rst = RESET_MASK[u];
            end
        end
    end

    // Granted-unit selection: one-hot grant and the granted unit's TX/done signals.
    always_comb begin
        grant_oh     = '0;
        sel_tx_data  = '0;
        sel_tx_start = 1'b0;
        for (int unsigned u = 0; u < N_UNITS; u++) begin
            if (unit_q == UW'(u)) begin
                grant_oh[u]  = 1'b1;
                sel_tx_data  = unit_tx_data_i[8*u +: 8];
                sel_tx_start = unit_tx_start_i[u];
            end
        end
        sel_done = |(unit_done_i & grant_oh);
    end

    assign in_grant = (state_q == GRANT);
    assign activity = rx_valid_i || sel_tx_start || tx_done_i;
    assign wd_clear = !in_grant || activity;
    assign timeout  = wd_expired && !activity;

    c2_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (wd_clear),
        .en_i     (in_grant),
        .expired_o(wd_expired)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        unit_d      = unit_q;
        mode_d      = mode_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        abort_d     = '0;
        byte_done_d = byte_done_q;
        nak_sent_d  = nak_sent_q;
        srst_cnt_d  = srst_cnt_q;
        inflight_d  = inflight_q;

        if (srst_cnt_q != '0) begin
            srst_cnt_d = srst_cnt_q - RW'(1);
        end

        // A unit byte is in flight from its start until the UART reports completion.
        if (tx_done_i) begin
            inflight_d = 1'b0;
        end
        if (in_grant && sel_tx_start) begin
            inflight_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    unit_d      = cmd_unit;
                    mode_d      = cmd_mode;
                    tx_start_d  = 1'b1;
                    byte_done_d = 1'b0;
                    if (cmd_valid) begin
                        tx_data_d = ACK_BYTE;
                        state_d   = ACK;
                        if (cmd_rst) begin
                            srst_cnt_d = RW'(RESET_CYC);
                        end
                    end else begin
                        tx_data_d  = NAK_CMD;
                        nak_sent_d = 1'b1;
                        state_d    = NAK;
                    end
                end
            end
            ACK: begin
                if (tx_done_i) begin
                    byte_done_d = 1'b1;
                end
                // The grant must not overlap the soft-reset pulse.
                if ((tx_done_i || byte_done_q) && (srst_cnt_d == '0)) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (sel_done) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d = NAK;
                    abort_d = grant_oh;
                    if (!inflight_d) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = NAK_TMO;
                        nak_sent_d = 1'b1;
                    end else begin
                        nak_sent_d = 1'b0;
                    end
                end
            end
            NAK: begin
                if (!nak_sent_q) begin
                    if (!inflight_d) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = NAK_TMO;
                        nak_sent_d = 1'b1;
                    end
                end else if (tx_done_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        soft_reset_d = (srst_cnt_d != '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            unit_q       <= '0;
            mode_q       <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            abort_q      <= '0;
            srst_cnt_q   <= '0;
            soft_reset_q <= 1'b0;
            inflight_q   <= 1'b0;
            byte_done_q  <= 1'b0;
            nak_sent_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            unit_q       <= unit_d;
            mode_q       <= mode_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            abort_q      <= abort_d;
            srst_cnt_q   <= srst_cnt_d;
            soft_reset_q <= soft_reset_d;
            inflight_q   <= inflight_d;
            byte_done_q  <= byte_done_d;
            nak_sent_q   <= nak_sent_d;
        end
    end

    // During a grant the UART is owned by the unit, so its TX path bypasses the hub registers.
    assign grant_o         = in_grant ? grant_oh : '0;
    assign mode_o          = in_grant ? mode_q : '0;
    assign unit_rx_valid_o = (in_grant && rx_valid_i) ? grant_oh : '0;
    assign tx_data_o       = in_grant ? sel_tx_data : tx_data_q;
    assign tx_start_o      = in_grant ? sel_tx_start : tx_start_q;
    assign unit_abort_o    = abort_q;
    assign soft_reset_o    = soft_reset_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_c2_dispatch_hub.sv
// Directed bench for c2_dispatch_hub: table of command vectors plus hand-written
// watchdog, done/timeout race and mid-session reset sequences.
module tb_c2_dispatch_hub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic [2:0]  grant;
    logic [0:0]  mode;
    logic [2:0]  unit_rx_valid;
    logic [23:0] unit_tx_data;
    logic [2:0]  unit_tx_start;
    logic [2:0]  unit_done;
    logic [2:0]  unit_abort;
    logic        soft_reset;
    logic        busy;

    int errors = 0;
    int checks = 0;

    c2_dispatch_hub #(
        .TIMEOUT_CYC(64)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .tx_data_o      (tx_data),
        .tx_start_o     (tx_start),
        .tx_done_i      (tx_done),
        .grant_o        (grant),
        .mode_o         (mode),
        .unit_rx_valid_o(unit_rx_valid),
        .unit_tx_data_i (unit_tx_data),
        .unit_tx_start_i(unit_tx_start),
        .unit_done_i    (unit_done),
        .unit_abort_o   (unit_abort),
        .soft_reset_o   (soft_reset),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        logic       srst;
        logic [2:0] grant;
        logic [0:0] mode;
        logic [7:0] ubyte;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Sends one command, answers the hub byte two cycles later, and returns at the first
    // cycle where a grant is visible or the hub has gone idle.
    task automatic issue_cmd(input logic [7:0] cmd, output int srst_n,
                             output logic [7:0] first_data, output logic first_start,
                             output logic settled);
        step(); rx_data = cmd; rx_valid = 1'b1; sample();
        step(); rx_valid = 1'b0; sample();
        first_start = tx_start;
        first_data  = tx_data;
        srst_n      = int'(soft_reset);
        step(); sample();
        srst_n += int'(soft_reset);
        step(); tx_done = 1'b1; sample();
        srst_n += int'(soft_reset);
        settled = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(); tx_done = 1'b0; sample();
            srst_n += int'(soft_reset);
            if (grant != 3'b000 || !busy) begin
                settled = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int         sr;
        logic [7:0] d;
        logic       s;
        logic       ok;
        int         k;

        vecs[0] = '{8'h43, 8'h06, 1'b1, 3'b010, 1'b1, 8'hB1};
        vecs[1] = '{8'h44, 8'h06, 1'b0, 3'b100, 1'b0, 8'hC2};
        vecs[2] = '{8'h46, 8'h15, 1'b0, 3'b000, 1'b0, 8'h00};
        vecs[3] = '{8'h3F, 8'h15, 1'b0, 3'b000, 1'b0, 8'h00};
        vecs[4] = '{8'h40, 8'h06, 1'b1, 3'b001, 1'b0, 8'hA0};
        vecs[5] = '{8'h45, 8'h06, 1'b0, 3'b100, 1'b1, 8'hC2};
        vecs[6] = '{8'hFF, 8'h15, 1'b0, 3'b000, 1'b0, 8'h00};
        vecs[7] = '{8'h41, 8'h06, 1'b1, 3'b001, 1'b1, 8'hA0};

        rst_n         = 1'b0;
        rx_data       = 8'h00;
        rx_valid      = 1'b0;
        tx_done       = 1'b0;
        unit_tx_data  = {8'hC2, 8'hB1, 8'hA0};
        unit_tx_start = 3'b000;
        unit_done     = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_grant", grant, 3'b000);
        chk("rst_abort", unit_abort, 3'b000);
        chk("rst_soft_reset", soft_reset, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        sample();

        foreach (vecs[n]) begin
            issue_cmd(vecs[n].rx, sr, d, s, ok);
            chk("reply_start", s, 1'b1);
            chk("reply_byte", d, vecs[n].tx);
            chk("soft_reset_cycles", sr, vecs[n].srst ? 4 : 0);
            chk("settled", ok, 1'b1);
            chk("grant", grant, vecs[n].grant);
            chk("mode", mode, vecs[n].mode);
            chk("busy", busy, vecs[n].grant != 3'b000);
            if (vecs[n].grant != 3'b000) begin
                step(); unit_tx_start = ~vecs[n].grant; sample();
                chk("foreign_start_ignored", tx_start, 1'b0);
                chk("tx_data_mux", tx_data, vecs[n].ubyte);
                step(); unit_tx_start = vecs[n].grant; rx_valid = 1'b1; rx_data = 8'h55; sample();
                chk("tx_start_pass", tx_start, 1'b1);
                chk("unit_rx_valid", unit_rx_valid, vecs[n].grant);
                step(); unit_tx_start = 3'b000; rx_valid = 1'b0; tx_done = 1'b1;
                unit_done = ~vecs[n].grant; sample();
                step(); tx_done = 1'b0; unit_done = vecs[n].grant; sample();
                chk("grant_hold", grant, vecs[n].grant);
                step(); unit_done = 3'b000; sample();
                chk("grant_release", grant, 3'b000);
                chk("busy_release", busy, 1'b0);
            end
        end

        // Watchdog release with nothing in flight.
        issue_cmd(8'h40, sr, d, s, ok);
        chk("tmo_grant", grant, 3'b001);
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            step(); sample();
            if (unit_abort != 3'b000) begin
                k = i;
                break;
            end
        end
        chk("tmo_latency", k, 64);
        chk("tmo_abort", unit_abort, 3'b001);
        chk("tmo_grant_drop", grant, 3'b000);
        chk("tmo_nak_start", tx_start, 1'b1);
        chk("tmo_nak_byte", tx_data, 8'h18);
        chk("tmo_busy", busy, 1'b1);
        step(); sample();
        chk("tmo_abort_one_cycle", unit_abort, 3'b000);
        chk("tmo_start_one_cycle", tx_start, 1'b0);
        step(); tx_done = 1'b1; sample();
        step(); tx_done = 1'b0; sample();
        chk("tmo_idle", busy, 1'b0);

        // Watchdog release while a unit byte is still in flight.
        issue_cmd(8'h40, sr, d, s, ok);
        step(); unit_tx_start = 3'b001; sample();
        step(); unit_tx_start = 3'b000; sample();
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            step(); sample();
            if (unit_abort != 3'b000) begin
                k = i;
                break;
            end
        end
        chk("inflight_abort_seen", k != 0, 1'b1);
        chk("inflight_nak_held", tx_start, 1'b0);
        step(); tx_done = 1'b1; sample();
        chk("inflight_nak_held2", tx_start, 1'b0);
        step(); tx_done = 1'b0; sample();
        chk("inflight_nak_start", tx_start, 1'b1);
        chk("inflight_nak_byte", tx_data, 8'h18);
        step(); tx_done = 1'b1; sample();
        step(); tx_done = 1'b0; sample();
        chk("inflight_idle", busy, 1'b0);

        // Done coinciding with expiry wins; a foreign unit's done is ignored.
        issue_cmd(8'h40, sr, d, s, ok);
        for (int i = 1; i <= 63; i++) begin
            step();
            unit_done = (i == 2) ? 3'b010 : ((i == 63) ? 3'b001 : 3'b000);
            sample();
            if (i == 63) begin
                chk("race_other_done_ignored", grant, 3'b001);
            end
        end
        step(); unit_done = 3'b000; sample();
        chk("race_no_abort", unit_abort, 3'b000);
        chk("race_grant_drop", grant, 3'b000);
        chk("race_no_nak", tx_start, 1'b0);
        chk("race_idle", busy, 1'b0);
        step(); sample();
        chk("race_no_abort_late", unit_abort, 3'b000);

        // Asynchronous reset in the middle of a grant.
        issue_cmd(8'h44, sr, d, s, ok);
        chk("mid_rst_grant_before", grant, 3'b100);
        step(); rx_valid = 1'b1; rx_data = 8'h10; unit_tx_start = 3'b100;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 3'b000);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rx_fwd", unit_rx_valid, 3'b000);
        chk("mid_rst_tx_start", tx_start, 1'b0);
        chk("mid_rst_tx_data", tx_data, 8'h00);
        chk("mid_rst_mode", mode, 1'b0);
        rx_valid = 1'b0;
        unit_tx_start = 3'b000;
        step();
        chk("mid_rst_no_abort", unit_abort, 3'b000);
        rst_n = 1'b1;
        sample();
        issue_cmd(8'h40, sr, d, s, ok);
        chk("post_rst_byte", d, 8'h06);
        chk("post_rst_srst", sr, 4);
        chk("post_rst_grant", grant, 3'b001);
        step(); unit_done = 3'b001; sample();
        step(); unit_done = 3'b000; sample();
        chk("post_rst_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
